// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sequencer
// Description : Iterative unsigned MULTU/DIVU unit with HI/LO commit and
//               pipeline stall generation for the MIPS execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             readReq,
    input  logic             readHi,
    output logic             stallOut,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] readData
);

    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);
    localparam logic            OP_MULTU  = 1'b0;
    localparam logic            OP_DIVU   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0]   dsr_q,   dsr_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               op_q,    op_d;

    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] acc_iter;

    assign accept = start && (state_q != S_RUN);

    // Shift-add step: carry out of the upper-half add becomes the new MSB.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dsr_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Restoring-divide step: the bit shifted out of the remainder is kept so
    // that divisors with the MSB set still compare correctly.
    always_comb begin
        div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_rem >= {1'b0, dsr_q});
        div_diff = div_rem[WIDTH-1:0] - dsr_q;
        if (div_ge) begin
            div_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    assign acc_iter = (op_q == OP_MULTU) ? mul_next : div_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dsr_d   = dsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                acc_d = acc_iter;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == LAST_ITER) begin
                    hi_d    = acc_iter[2*WIDTH-1:WIDTH];
                    lo_d    = acc_iter[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept never coincides with S_RUN, so it cannot clash with the iteration above.
        if (accept) begin
            dsr_d = opB;
            op_d  = op;
            acc_d = {{WIDTH{1'b0}}, opA};
            cnt_d = '0;
            if ((op == OP_DIVU) && (opB == '0)) begin
                hi_d    = opA;
                lo_d    = {WIDTH{1'b1}};
                state_d = S_DONE;
            end else begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dsr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_MULTU;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dsr_q   <= dsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign stallOut = busy && (start || readReq);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign readData = readHi ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sequencer
// Description : Randomized self-checking bench for mdu_sequencer against an
//               arithmetic reference model of HI/LO results and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic          readReq;
    logic          readHi;
    logic          stallOut;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  readData;

    int            n_checks;
    int            n_fail;
    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;

    mdu_sequencer #(.WIDTH(W), .CNTW(6)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .readReq  (readReq),
        .readHi   (readHi),
        .stallOut (stallOut),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .readData (readData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one MULTU/DIVU instruction.
    function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [2*W-1:0] p;
        if (!o) begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            eh = p[2*W-1:W];
            el = p[W-1:0];
        end else if (b == '0) begin
            eh = a;
            el = '1;
        end else begin
            eh = a % b;
            el = a / b;
        end
    endfunction

    task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        op      = o;
        opA     = a;
        opB     = b;
        readReq = 1'b0;
    endtask

    // Follows one already-driven request from its accepting edge to completion.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input bit chain,
                          input logic no, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W-1:0] eh, el;
        int           lat, nbusy;
        bit           seen;
        model(o, a, b, eh, el);
        lat   = (o && b == '0) ? 0 : W;
        nbusy = 0;
        seen  = 0;
        @(posedge clock);
        for (int j = 0; j <= lat + 4 && !seen; j++) begin
            @(negedge clock);
            start   = 1'b0;
            readReq = 1'b0;
            op      = 1'($urandom);
            opA     = $urandom;
            opB     = $urandom;
            if (noise && j < lat) begin
                readReq = 1'($urandom);
                readHi  = 1'($urandom);
                start   = ($urandom % 4 == 0);
            end
            if (j == lat) begin
                readReq = 1'($urandom);
                readHi  = 1'($urandom);
                if (chain) begin
                    start = 1'b1;
                    op    = no;
                    opA   = na;
                    opB   = nb;
                end
            end
            #1;
            chk("stall", stallOut, (j < lat) && (start || readReq));
            if (busy) nbusy++;
            if (done) begin
                seen = 1;
                chk("latency", 64'(j), 64'(lat));
                chk("hi", hi, eh);
                chk("lo", lo, el);
                chk("rdata_new", readData, readHi ? eh : el);
            end else if (j < lat) begin
                chk("rdata_old", readData, readHi ? m_hi : m_lo);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("busy_cycles", 64'(nbusy), 64'(lat));
        m_hi = eh;
        m_lo = el;
        if (!chain) begin
            @(negedge clock);
            start   = 1'b0;
            readReq = 1'b0;
            #1;
            chk("done_pulse", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("hold_hi", hi, m_hi);
            chk("hold_lo", lo, m_lo);
        end
    endtask

    initial begin
        logic          co, no;
        logic [W-1:0]  ca, cb, na, nb;
        bit            chain;
        int            ndone;

        n_checks = 0;
        n_fail   = 0;
        m_hi     = '0;
        m_lo     = '0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 1'b0;
        opA      = '0;
        opB      = '0;
        readReq  = 1'b1;
        readHi   = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stallOut, 0);

        // Directed cases
        issue(1'b0, 32'd7, 32'd6);
        run_op(1'b0, 32'd7, 32'd6, 0, 0, 0, 0, 0);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        issue(1'b1, 32'd100, 32'd7);
        run_op(1'b1, 32'd100, 32'd7, 0, 1, 1'b1, 32'd1000, 32'd3);
        run_op(1'b1, 32'd1000, 32'd3, 0, 0, 0, 0, 0);
        issue(1'b1, 32'd5, 32'd0);
        run_op(1'b1, 32'd5, 32'd0, 0, 0, 0, 0, 0);
        issue(1'b1, 32'hFFFF_FFF0, 32'h8000_0001);
        run_op(1'b1, 32'hFFFF_FFF0, 32'h8000_0001, 1, 0, 0, 0, 0);
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 1, 0, 0, 0, 0);

        // Reset during RUN aborts the sequence
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        @(posedge clock);
        repeat (10) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        m_hi  = '0;
        m_lo  = '0;
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 0);
        issue(1'b0, 32'd3, 32'd3);
        run_op(1'b0, 32'd3, 32'd3, 0, 0, 0, 0, 0);

        // Randomized sequences with optional back-to-back chaining
        co = 1'($urandom);
        ca = $urandom;
        cb = $urandom;
        issue(co, ca, cb);
        for (int i = 0; i < 40; i++) begin
            no = 1'($urandom);
            na = $urandom;
            case ($urandom % 6)
                0:       nb = '0;
                1:       nb = 32'($urandom % 16);
                default: nb = $urandom;
            endcase
            chain = (i < 39) && ($urandom % 3 == 0);
            run_op(co, ca, cb, 1'($urandom), chain, no, na, nb);
            if (!chain && i < 39) issue(no, na, nb);
            co = no;
            ca = na;
            cb = nb;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
